// File: rtl/ppc_fetch_unit.sv
// Instruction fetch unit: issues in-order word reads, buffers the returned
// words with their addresses, and handles redirects by dropping stale data.
module ppc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] instruction_addr
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outs_next;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        fifo_data [FIFO_DEPTH];
    logic [31:0]        fifo_addr [FIFO_DEPTH];
    logic               redirect_q;
    logic               credit_ok;
    logic               req_xfer;
    logic               rsp_dec;
    logic               push;
    logic               pop;
    logic [31:0]        rsp_addr;

    // Request credit: in-flight plus buffered words must leave room in the buffer
    assign credit_ok = (SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);

    // Request valid is decoded from registered state and counters; the cycle
    // right after a redirect is always quiet
    assign mem_req_valid = (state == RUN) && fetch_enable && !redirect_q && credit_ok;
    assign mem_req_addr  = pc;
    assign req_xfer      = mem_req_valid && mem_req_ready;

    assign instruction_valid = (fifo_count != '0);
    assign instruction       = fifo_data[rd_ptr];
    assign instruction_addr  = fifo_addr[rd_ptr];
    assign pop               = instruction_valid && instruction_ready;

    // Responses are only kept outside FLUSH and never in a redirect cycle
    assign push    = mem_rsp_valid && (state != FLUSH) && !redirect_valid;
    assign rsp_dec = mem_rsp_valid && (outstanding != '0);

    // Outside FLUSH the in-flight requests are contiguous and end just below pc
    assign rsp_addr  = pc - (32'(outstanding) << 2);
    assign outs_next = outstanding + CNT_W'(req_xfer) - CNT_W'(rsp_dec);

    // Control state, fetch PC and outstanding-request counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            redirect_q  <= 1'b0;
        end else begin
            outstanding <= outs_next;
            redirect_q  <= redirect_valid;
            if (redirect_valid) begin
                pc <= redirect_addr & ~32'h0000_0003;
                if (outs_next != '0) begin
                    state <= FLUSH;
                end else begin
                    state <= fetch_enable ? RUN : IDLE;
                end
            end else begin
                if (req_xfer) begin
                    pc <= pc + 32'd4;
                end
                case (state)
                    IDLE:    if (fetch_enable) state <= RUN;
                    RUN:     if (!fetch_enable) state <= IDLE;
                    FLUSH:   if (outs_next == '0) state <= fetch_enable ? RUN : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Instruction buffer: circular store of (word, address) pairs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rsp_data;
                fifo_addr[wr_ptr] <= rsp_addr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_ppc_fetch_unit.sv
// Bench for ppc_fetch_unit: in-order memory model plus an address-stream
// reference model covering directed scenarios and randomized traffic.
module tb_ppc_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instruction;
    logic [31:0] instruction_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rsp_q[$];
    logic [31:0] obs_req[$];
    logic [31:0] obs_ia[$];
    logic [31:0] obs_id[$];
    logic        rsp_en;
    int unsigned rsp_pct;

    logic        l_xfer, l_pop, l_rsp, l_redirect, l_fe, l_req_valid, l_req_ready;
    logic [31:0] l_req_addr, l_pop_addr, l_pop_data;

    ppc_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_enable      (fetch_enable),
        .redirect_valid    (redirect_valid),
        .redirect_addr     (redirect_addr),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .instruction_addr  (instruction_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: memory answers at the falling edge, events sampled before the
    // rising edge, returns 1 time unit after the rising edge
    task automatic step();
        logic [31:0] a;
        @(negedge clk);
        if (rst && rsp_en && rsp_q.size() > 0 && ($urandom_range(99, 0) < rsp_pct)) begin
            a = rsp_q.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(a);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        #1;
        l_req_valid = mem_req_valid;
        l_req_ready = mem_req_ready;
        l_req_addr  = mem_req_addr;
        l_xfer      = mem_req_valid && mem_req_ready;
        l_pop       = instruction_valid && instruction_ready;
        l_pop_addr  = instruction_addr;
        l_pop_data  = instruction;
        l_rsp       = mem_rsp_valid;
        l_redirect  = redirect_valid;
        l_fe        = fetch_enable;
        if (l_xfer) begin
            obs_req.push_back(mem_req_addr);
            rsp_q.push_back(mem_req_addr);
        end
        if (l_pop) begin
            obs_ia.push_back(instruction_addr);
            obs_id.push_back(instruction);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_req.delete();
        obs_ia.delete();
        obs_id.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fetch_enable = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        mem_req_ready = 1'b1;
        instruction_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        rsp_en = 1'b1;
        rsp_pct = 100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_q.delete();
        clear_obs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fetch_enable = 1'b1;
        mem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        instruction_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", mem_req_addr, RESET_PC); end
        n_checks++; if (instruction_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", instruction_valid); end
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        n_checks++; if (instruction_addr !== 32'h0) begin n_fail++; $display("FAIL reset_instr_addr: got %h expected 0", instruction_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_enable = 1'b1;
        repeat (30) step();
        n_checks++; if (obs_ia.size() < 20) begin n_fail++; $display("FAIL stream_pop_count: got %0d expected >= 20", obs_ia.size()); end
        for (int i = 0; i < obs_req.size(); i++) begin
            n_checks++; if (obs_req[i] !== RESET_PC + 32'(i * 4)) begin n_fail++; $display("FAIL stream_req[%0d]: got %h expected %h", i, obs_req[i], RESET_PC + 32'(i * 4)); end
        end
        for (int i = 0; i < obs_ia.size(); i++) begin
            n_checks++; if (obs_ia[i] !== RESET_PC + 32'(i * 4) || obs_id[i] !== mem_word(RESET_PC + 32'(i * 4))) begin
                n_fail++; $display("FAIL stream_instr[%0d]: got %h/%h expected %h/%h", i, obs_ia[i], obs_id[i], RESET_PC + 32'(i * 4), mem_word(RESET_PC + 32'(i * 4)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_enable = 1'b1;
        instruction_ready = 1'b0;
        repeat (20) step();
        n_checks++; if (obs_req.size() != FIFO_DEPTH) begin n_fail++; $display("FAIL bp_req_count: got %0d expected %0d", obs_req.size(), FIFO_DEPTH); end
        n_checks++; if (instruction_valid !== 1'b1 || instruction_addr !== RESET_PC) begin n_fail++; $display("FAIL bp_hold: got valid %b addr %h expected 1 %h", instruction_valid, instruction_addr, RESET_PC); end
        instruction_ready = 1'b1;
        repeat (30) step();
        n_checks++; if (obs_ia.size() < 20) begin n_fail++; $display("FAIL bp_resume_count: got %0d expected >= 20", obs_ia.size()); end
        for (int i = 0; i < obs_ia.size(); i++) begin
            n_checks++; if (obs_ia[i] !== RESET_PC + 32'(i * 4) || obs_id[i] !== mem_word(RESET_PC + 32'(i * 4))) begin
                n_fail++; $display("FAIL bp_instr[%0d]: got %h/%h expected %h", i, obs_ia[i], obs_id[i], RESET_PC + 32'(i * 4));
            end
        end
        for (int i = 0; i < obs_req.size(); i++) begin
            n_checks++; if (obs_req[i] !== RESET_PC + 32'(i * 4)) begin n_fail++; $display("FAIL bp_req[%0d]: got %h expected %h", i, obs_req[i], RESET_PC + 32'(i * 4)); end
        end
    endtask

    task automatic test_redirect_flush();
        int g;
        do_reset();
        fetch_enable = 1'b1;
        instruction_ready = 1'b0;
        rsp_en = 1'b0;
        g = 0;
        while (obs_req.size() < 3 && g < 40) begin step(); g++; end
        mem_req_ready = 1'b0;
        n_checks++; if (obs_req.size() != 3) begin n_fail++; $display("FAIL flush_setup_reqs: got %0d expected 3", obs_req.size()); end
        redirect_addr = 32'h0000_1003;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        instruction_ready = 1'b1;
        clear_obs();
        repeat (4) step();
        n_checks++; if (obs_req.size() != 0) begin n_fail++; $display("FAIL flush_no_req: got %0d requests expected 0", obs_req.size()); end
        rsp_en = 1'b1;
        repeat (20) step();
        n_checks++; if (obs_req.size() < 1 || obs_req[0] !== 32'h0000_1000) begin n_fail++; $display("FAIL flush_first_req: got %h expected 00001000", (obs_req.size() > 0) ? obs_req[0] : 32'hx); end
        n_checks++; if (obs_ia.size() < 1 || obs_ia[0] !== 32'h0000_1000 || obs_id[0] !== mem_word(32'h0000_1000)) begin
            n_fail++; $display("FAIL flush_first_instr: got %h expected 00001000", (obs_ia.size() > 0) ? obs_ia[0] : 32'hx);
        end
        n_checks++; if (obs_ia.size() < 2 || obs_ia[1] !== 32'h0000_1004) begin n_fail++; $display("FAIL flush_second_instr: got %h expected 00001004", (obs_ia.size() > 1) ? obs_ia[1] : 32'hx); end
    endtask

    task automatic test_stall_wrap();
        do_reset();
        fetch_enable = 1'b1;
        mem_req_ready = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL stall_stable[%0d]: got %b/%h expected 1/%h", i, mem_req_valid, mem_req_addr, RESET_PC); end
        end
        redirect_addr = 32'hFFFF_FFFC;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        clear_obs();
        repeat (10) step();
        n_checks++; if (obs_req.size() < 2 || obs_req[0] !== 32'hFFFF_FFFC || obs_req[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_req: got %h,%h expected fffffffc,00000000", (obs_req.size() > 0) ? obs_req[0] : 32'hx, (obs_req.size() > 1) ? obs_req[1] : 32'hx);
        end
        n_checks++; if (obs_ia.size() < 2 || obs_ia[0] !== 32'hFFFF_FFFC || obs_ia[1] !== 32'h0 || obs_id[1] !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL wrap_instr: got %h,%h expected fffffffc,00000000", (obs_ia.size() > 0) ? obs_ia[0] : 32'hx, (obs_ia.size() > 1) ? obs_ia[1] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        int g;
        do_reset();
        fetch_enable = 1'b1;
        instruction_ready = 1'b0;
        rsp_en = 1'b0;
        g = 0;
        while (obs_req.size() < 4 && g < 40) begin step(); g++; end
        rsp_en = 1'b1;
        repeat (2) step();
        rsp_en = 1'b0;
        step();
        n_checks++; if (instruction_valid !== 1'b1 || rsp_q.size() != 2) begin n_fail++; $display("FAIL areset_setup: got valid %b pending %0d expected 1 2", instruction_valid, rsp_q.size()); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL areset_req: got %b/%h expected 0/%h", mem_req_valid, mem_req_addr, RESET_PC); end
        n_checks++; if (instruction_valid !== 1'b0) begin n_fail++; $display("FAIL areset_instr_valid: got %b expected 0", instruction_valid); end
        n_checks++; if (instruction !== 32'h0 || instruction_addr !== 32'h0) begin n_fail++; $display("FAIL areset_instr: got %h/%h expected 0/0", instruction, instruction_addr); end
        rsp_q.delete();
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_en = 1'b1;
        instruction_ready = 1'b1;
        repeat (12) step();
        n_checks++; if (obs_req.size() < 1 || obs_req[0] !== RESET_PC) begin n_fail++; $display("FAIL areset_first_req: got %h expected %h", (obs_req.size() > 0) ? obs_req[0] : 32'hx, RESET_PC); end
        n_checks++; if (obs_ia.size() < 1 || obs_ia[0] !== RESET_PC || obs_id[0] !== mem_word(RESET_PC)) begin
            n_fail++; $display("FAIL areset_first_instr: got %h expected %h", (obs_ia.size() > 0) ? obs_ia[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        do_reset();
        fetch_enable = 1'b1;
        repeat (8) step();
        redirect_addr = 32'h0000_2000;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (!(l_pop && l_rsp && l_xfer)) begin n_fail++; $display("FAIL b2b_events: got pop %b rsp %b xfer %b expected 1 1 1", l_pop, l_rsp, l_xfer); end
        n_checks++; if (instruction_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_fifo_empty: got %b expected 0", instruction_valid); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_req_quiet: got %b expected 0", mem_req_valid); end
        idx = obs_ia.size();
        for (int i = 0; i < idx; i++) begin
            n_checks++; if (obs_ia[i] !== RESET_PC + 32'(i * 4) || obs_id[i] !== mem_word(RESET_PC + 32'(i * 4))) begin
                n_fail++; $display("FAIL b2b_old[%0d]: got %h expected %h", i, obs_ia[i], RESET_PC + 32'(i * 4));
            end
        end
        repeat (15) step();
        n_checks++; if (obs_ia.size() <= idx || obs_ia[idx] !== 32'h0000_2000 || obs_id[idx] !== mem_word(32'h0000_2000)) begin
            n_fail++; $display("FAIL b2b_new_first: got %h expected 00002000", (obs_ia.size() > idx) ? obs_ia[idx] : 32'hx);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_req, exp_ins, p_addr;
        logic        p_valid, p_ready, p_fe, p_redir;
        int          pops;
        do_reset();
        exp_req = RESET_PC;
        exp_ins = RESET_PC;
        p_valid = 1'b0; p_ready = 1'b0; p_fe = 1'b0; p_redir = 1'b0; p_addr = '0;
        pops = 0;
        rsp_pct = 60;
        for (int c = 0; c < 2000; c++) begin
            fetch_enable      = ($urandom_range(9, 0) != 0);
            mem_req_ready     = ($urandom_range(3, 0) != 0);
            instruction_ready = ($urandom_range(3, 0) != 0);
            redirect_valid    = ($urandom_range(39, 0) == 0);
            redirect_addr     = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step();
            if (l_xfer) begin
                n_checks++; if (l_req_addr !== exp_req) begin n_fail++; $display("FAIL rand_req c%0d: got %h expected %h", c, l_req_addr, exp_req); end
                exp_req = exp_req + 32'd4;
            end
            if (l_pop) begin
                pops++;
                n_checks++; if (l_pop_addr !== exp_ins || l_pop_data !== mem_word(exp_ins)) begin
                    n_fail++; $display("FAIL rand_instr c%0d: got %h/%h expected %h/%h", c, l_pop_addr, l_pop_data, exp_ins, mem_word(exp_ins));
                end
                exp_ins = exp_ins + 32'd4;
            end
            if (p_valid && !p_ready && p_fe && l_fe && !p_redir) begin
                n_checks++; if (l_req_valid !== 1'b1 || l_req_addr !== p_addr) begin n_fail++; $display("FAIL rand_stable c%0d: got %b/%h expected 1/%h", c, l_req_valid, l_req_addr, p_addr); end
            end
            if (l_redirect) begin
                exp_req = redirect_addr & ~32'h3;
                exp_ins = exp_req;
            end
            n_checks++; if (rsp_q.size() > FIFO_DEPTH) begin n_fail++; $display("FAIL rand_outstanding c%0d: got %0d expected <= %0d", c, rsp_q.size(), FIFO_DEPTH); end
            p_valid = l_req_valid; p_ready = l_req_ready; p_fe = l_fe; p_redir = l_redirect; p_addr = l_req_addr;
        end
        redirect_valid = 1'b0;
        n_checks++; if (pops < 200) begin n_fail++; $display("FAIL rand_pop_volume: got %0d expected >= 200", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_stall_wrap();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppc_fetch_unit.md
PPC_FETCH_UNIT -- requirements
Module: ppc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; word aligned.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction buffer entries; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fetch_enable  input  1  when high, the unit may issue new memory requests.
REQ-006 redirect_valid  input  1  one-cycle pulse; restart fetch at redirect_addr.
REQ-007 redirect_addr  input  32  new fetch address; low two bits ignored and treated as 0.
REQ-008 mem_req_valid  output  1  read request to instruction memory.
REQ-009 mem_req_ready  input  1  memory accepts request.
REQ-010 mem_req_addr  output  32  word-aligned request address.
REQ-011 mem_rsp_valid  input  1  read data valid; responses return in request order, never back-pressured.
REQ-012 mem_rsp_data  input  32  instruction word.
REQ-013 instruction_valid  output  1  instruction available to the core.
REQ-014 instruction_ready  input  1  core accepts the instruction.
REQ-015 instruction  output  32  instruction word to the core.
REQ-016 instruction_addr  output  32  fetch address of the presented instruction.

Function
REQ-017 States: IDLE, RUN, FLUSH; IDLE->RUN when fetch_enable=1; RUN->IDLE when fetch_enable=0 (outstanding requests still complete and are buffered).
REQ-018 Request handshake: a request transfers on a cycle with mem_req_valid=1 and mem_req_ready=1; mem_req_valid and mem_req_addr stay stable until transfer unless a redirect occurs.
REQ-019 mem_req_valid=1 only in RUN, with fetch_enable=1 and (outstanding + fifo_count) < FIFO_DEPTH, using start-of-cycle values; the FIFO can never overflow.
REQ-020 PC increments by 4 per transferred request; wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 outstanding counter: +1 per transferred request, -1 per mem_rsp_valid; both in one cycle -> unchanged; range 0..FIFO_DEPTH.
REQ-022 Each response in RUN/IDLE is written into the FIFO with its address; it appears on instruction/instruction_addr no earlier than the next cycle (1-cycle min latency, no combinational rsp->instruction path).
REQ-023 Output handshake: an entry pops on instruction_valid=1 and instruction_ready=1; instruction_valid=1 iff FIFO non-empty; outputs stable while valid and not ready.
REQ-024 Simultaneous push and pop on a full or empty FIFO are both performed; count unchanged (empty: entry visible next cycle).
REQ-025 Redirect (any state): FIFO emptied, PC <= redirect_addr & ~3, mem_req_valid=0 next cycle; request transferring in the same cycle counts as outstanding and its response is discarded.
REQ-026 Redirect with outstanding (after same-cycle updates) > 0 -> FLUSH; otherwise -> RUN if fetch_enable else IDLE.
REQ-027 In FLUSH: no requests issued; every response discarded; outstanding==0 -> RUN (fetch_enable=1) or IDLE.
REQ-028 Redirect during FLUSH: PC updated to the new address, remain in FLUSH.
REQ-029 Redirect with a same-cycle response: response discarded; same-cycle pop completes, FIFO empty next cycle.

Reset
REQ-030 While rst=0: state IDLE, PC=RESET_PC, outstanding=0, FIFO empty, mem_req_valid=0, instruction_valid=0, mem_req_addr=RESET_PC, instruction=0, instruction_addr=0.
REQ-031 Reset takes effect immediately on rst falling, regardless of clk; in-flight requests and responses forgotten; first request no earlier than the first rising edge after rst rises.

Verification
REQ-032 Reset release, fetch_enable=1, memory ready always, 1-cycle response, core always ready -> requests 0x0,0x4,0x8...; instruction_addr 0x0,0x4,0x8 in order with matching data.
REQ-033 Core ready=0 for 20 cycles -> exactly 4 requests issued, instruction_valid held at address 0x0; ready=1 -> 4 pops, fetch resumes with no loss or duplication.
REQ-034 Redirect to 0x1003 with 3 outstanding -> FLUSH, 3 responses discarded, next request 0x1000, first instruction_addr 0x1000.
REQ-035 mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable; PC=0xFFFF_FFFC -> next request 0x0000_0000.
REQ-036 rst asserted mid-stream with 2 outstanding and 2 buffered -> all outputs at reset values before next clk edge; after release first request = RESET_PC.
REQ-037 Redirect in same cycle as pop, response and request transfer -> pop completes, response dropped, that request's response dropped, FIFO empty next cycle.
